// File: rtl/keypad_decoder.sv
// Keypad decoder: accumulates 4-column scan frames, debounces press/release over
// whole frames and decodes a single pressed key to a hex code with a one-cycle strobe.
module keypad_decoder #(
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rcbits,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] N_FRAMES = CNT_W'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED, RELEASE_DB} state_t;

   state_t           r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
   logic [3:0]       r_cand, w_cand_nx;
   logic             w_accept;

   logic [1:0] r_fcnt, w_fcnt_m;
   logic [3:0] r_fcode, w_fcode_m;

   logic [3:0] w_rows, w_cols;
   logic       w_col_ok;
   logic [1:0] w_col, w_row;
   logic [2:0] w_pop, w_sum;
   logic [3:0] w_code;
   logic       w_frame_end, w_none, w_single;

   assign w_rows      = rcbits[7:4];
   assign w_cols      = rcbits[3:0];
   assign w_frame_end = (w_cols == 4'b0001);
   assign w_pop       = 3'(w_rows[0]) + 3'(w_rows[1]) + 3'(w_rows[2]) + 3'(w_rows[3]);
   assign w_cnt_inc   = r_cnt + CNT_W'(1);

   // Column index from the one-hot column field; anything else is not a valid sample
   always_comb begin
      w_col_ok = 1'b1;
      w_col    = 2'd0;
      case (w_cols)
         4'b0001: w_col = 2'd0;
         4'b0010: w_col = 2'd1;
         4'b0100: w_col = 2'd2;
         4'b1000: w_col = 2'd3;
         default: w_col_ok = 1'b0;
      endcase
   end

   // Lowest pressed row; only meaningful when a single key is down in the frame
   always_comb begin
      if (w_rows[0])      w_row = 2'd0;
      else if (w_rows[1]) w_row = 2'd1;
      else if (w_rows[2]) w_row = 2'd2;
      else                w_row = 2'd3;
   end

   // Keypad map (row,col) -> hex code
   always_comb begin
      case ({w_row, w_col})
         4'b0000: w_code = 4'h1;
         4'b0001: w_code = 4'h2;
         4'b0010: w_code = 4'h3;
         4'b0011: w_code = 4'hA;
         4'b0100: w_code = 4'h4;
         4'b0101: w_code = 4'h5;
         4'b0110: w_code = 4'h6;
         4'b0111: w_code = 4'hB;
         4'b1000: w_code = 4'h7;
         4'b1001: w_code = 4'h8;
         4'b1010: w_code = 4'h9;
         4'b1011: w_code = 4'hC;
         4'b1100: w_code = 4'hE;
         4'b1101: w_code = 4'h0;
         4'b1110: w_code = 4'hF;
         default: w_code = 4'hD;
      endcase
   end

   // Frame accumulators with the current cycle merged in (saturating key count)
   always_comb begin
      w_sum     = 3'(r_fcnt) + w_pop;
      w_fcnt_m  = r_fcnt;
      w_fcode_m = r_fcode;
      if (w_col_ok) begin
         w_fcnt_m = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
         if (w_rows != 4'd0) w_fcode_m = w_code;
      end
      w_none   = (w_fcnt_m == 2'd0);
      w_single = (w_fcnt_m == 2'd1);
   end

   // Frame accumulator registers, cleared at each frame end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fcnt  <= 2'd0;
         r_fcode <= 4'h0;
      end else if (w_frame_end) begin
         r_fcnt  <= 2'd0;
         r_fcode <= 4'h0;
      end else begin
         r_fcnt  <= w_fcnt_m;
         r_fcode <= w_fcode_m;
      end
   end

   // Debounce FSM next state, evaluated only on frame-end cycles
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cand_nx  = r_cand;
      w_accept   = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            IDLE: begin
               if (w_single) begin
                  w_cand_nx = w_fcode_m;
                  w_cnt_nx  = CNT_W'(1);
                  if (N_FRAMES == CNT_W'(1)) begin
                     w_state_nx = PRESSED;
                     w_accept   = 1'b1;
                  end else begin
                     w_state_nx = CANDIDATE;
                  end
               end
            end
            CANDIDATE: begin
               if (w_single && (w_fcode_m == r_cand)) begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc == N_FRAMES) begin
                     w_state_nx = PRESSED;
                     w_accept   = 1'b1;
                  end
               end else begin
                  w_state_nx = IDLE;
                  w_cnt_nx   = '0;
               end
            end
            PRESSED: begin
               if (w_none) begin
                  w_cnt_nx   = CNT_W'(1);
                  w_state_nx = (N_FRAMES == CNT_W'(1)) ? IDLE : RELEASE_DB;
               end
            end
            default: begin
               if (w_none) begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc == N_FRAMES) begin
                     w_state_nx = IDLE;
                     w_cnt_nx   = '0;
                  end
               end else begin
                  w_state_nx = PRESSED;
                  w_cnt_nx   = '0;
               end
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cand  <= 4'h0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_cand  <= w_cand_nx;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key       <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         if (w_accept) key <= w_cand_nx;
         key_valid <= w_accept;
         key_held  <= (w_state_nx == PRESSED) || (w_state_nx == RELEASE_DB);
      end
   end

endmodule
